bus_responder: RTL and testbench
================================

# bus_responder

Memory-mapped bus target for the k6502 core: the responder end of the CPU address/data bus. It samples the CPU's phase-2 strobe and bus signals in the `ph0` domain and decodes a configurable address window. For each hit it runs one request/acknowledge transaction on a backing memory port, and stalls the CPU through `cpu_rdy` until that transaction completes. Read data is driven back to the CPU while `cpu_ph2` remains high.

## Interface
- `BASE_ADDR`, 16'h0000, window base; compared under mask.
- `ADDR_MASK`, 16'hF800, bits that take part in the decode; hit when `(cpu_a & ADDR_MASK) == BASE_ADDR`.
- `TIMEOUT`, 16, ack wait limit in clocks; range 1..255; used only with the timeout feature.
- `ph0` in 1: sole clock; all logic on its rising edge.
- `reset` in 1: reset is synchronous and active-high.
- `cpu_ph2` in 1: CPU phase-2 level, taken from the clockgen `ph2_out`.
- `cpu_a` in 16: CPU address.
- `cpu_rw` in 1: 1 = read, 0 = write.
- `cpu_d_in` in 8: CPU write data.
- `cpu_d_out` out 8: read data returned to the CPU.
- `cpu_d_oe` out 1: read-data drive enable.
- `cpu_rdy` out 1: 1 = no stall.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out 16, `mem_wdata` out 8: memory request.
- `mem_rdata` in 8, `mem_ack` in 1: memory response.
- `bus_err` out 1: sticky timeout flag.

## Operation
- **Registered outputs.** Every output is registered.
- **Reset values.** `cpu_d_out`=0, `cpu_d_oe`=0, `cpu_rdy`=1, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `bus_err`=0. State = IDLE.
- **Start edge.** A start edge occurs when the registered `ph2_q` is 0 and `cpu_ph2` is 1.
- **IDLE, start edge with hit.**
  - Capture `cpu_a` → `mem_addr`, `!cpu_rw` → `mem_we`, `cpu_d_in` → `mem_wdata`.
  - Set `mem_req`=1 and `cpu_rdy`=0.
  - Go to REQ.
- **IDLE, start edge with miss.** No action; `cpu_rdy` stays 1 and `cpu_d_oe` stays 0.
- **REQ, `mem_ack`=1.**
  - Set `mem_req`=0 and `cpu_rdy`=1.
  - On a read, `cpu_d_out` ← `mem_rdata`, and `cpu_d_oe` ← `cpu_ph2`.
  - Go to HOLD.
- **HOLD.**
  - `cpu_d_oe` stays 1 while `cpu_ph2` is high.
  - On the first clock with `cpu_ph2`=0: `cpu_d_oe`=0, go to IDLE.
  - `cpu_d_out` keeps its last value.
- **Stall scope.** Writes stall exactly like reads. The k6502 honours `cpu_rdy` on both.
- **Captured values.** Address, rw and write data are captured once per transaction. Later changes to them are ignored.

## Timing
- **Request issue.** Start edge sampled at clock N → `mem_req`=1 and `cpu_rdy`=0 at N+1.
- **Ack sampling.** `mem_ack` is sampled in REQ. Ack at clock M (M ≥ N+1) → data valid, `cpu_d_oe`=1 and `cpu_rdy`=1 at M+1.
- **Minimum latency.** Two clocks from start edge to read data.
- **Boundary conditions.**
  - `cpu_ph2` falls while in REQ: the transaction still completes. Read data is latched, but `cpu_d_oe` stays 0 and the state returns to IDLE at M+1.
  - Start edges outside IDLE are ignored.
  - `mem_ack` outside REQ is ignored.
  - A start edge on the same clock that HOLD exits is not seen. That cannot occur, because `ph2` must be low first.
  - `reset` mid-transaction: all outputs take their reset values at the next edge and any later `mem_ack` is ignored. `reset` has priority over every other event.

## Configuration
- **Macro:** `BUS_RESPONDER_TIMEOUT_EN`.
- **Defined.**
  - An 8-bit counter clears on entry to REQ and increments each clock in REQ without ack.
  - When it reaches `TIMEOUT`: `mem_req`=0, `cpu_rdy`=1, read data = 8'hFF, `bus_err`=1, then HOLD.
  - `bus_err` stays 1 until `reset`.
  - Ack on the same clock as expiry wins.
- **Undefined.** REQ waits indefinitely. `bus_err` is tied 0, and the port remains present.

## Structure
- **`bus_responder_pkg`:**
  - state typedef: IDLE, REQ, HOLD;
  - `RW_READ` = 1'b1;
  - `TIMEOUT_DEFAULT` = 16;
  - `TIMEOUT_ERR_DATA` = 8'hFF.
- **Sub-module `ph2_edge_detect`.** Registers `cpu_ph2` and outputs the rise and fall pulses. `bus_responder` instantiates it once.

## Test plan
- **Read hit, zero wait.** `cpu_a`=16'h0123, `cpu_rw`=1, `mem_ack` tied 1, `mem_rdata`=8'hA5 → `mem_req` for 1 clock; `cpu_d_out`=8'hA5 with `cpu_d_oe`=1 at start+2; `cpu_rdy` low exactly 1 clock.
- **Write hit, 3-clock wait.** `cpu_a`=16'h07FF, `cpu_rw`=0, `cpu_d_in`=8'h3C, ack 3 clocks after req → `mem_we`=1, `mem_wdata`=8'h3C, `mem_addr`=16'h07FF; `cpu_rdy`=0 for 3 clocks; `cpu_d_oe` never 1.
- **Miss.** `cpu_a`=16'h0800 with default parameters → `mem_req`, `cpu_rdy` and `cpu_d_oe` are unchanged from idle.
- **Reset mid-REQ.** `reset` asserted 2 clocks after `mem_req` rises → next clock `mem_req`=0, `cpu_rdy`=1; a subsequent `mem_ack` produces no `cpu_d_oe`.
- **Timeout.** With `BUS_RESPONDER_TIMEOUT_EN`, `TIMEOUT`=4 and no ack → `mem_req` drops after 4 clocks; `cpu_d_out`=8'hFF; `bus_err`=1 and it persists over the next hit read.
- **Early ph2 fall.** `cpu_ph2` falls before ack on a read → after ack, `cpu_d_oe` stays 0 and the state returns to IDLE; the next cycle is serviced normally.

Source files
------------

// File: rtl/bus_responder_pkg.sv
// bus_responder_pkg: shared types and constants for the k6502 bus responder.
//   state_e          - transaction FSM states (IDLE, REQ, HOLD)
//   RW_READ          - cpu_rw level that means "read"
//   TIMEOUT_DEFAULT  - default ack wait limit in clocks
//   TIMEOUT_ERR_DATA - read data returned when a request times out
package bus_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic        RW_READ          = 1'b1;
  localparam int unsigned TIMEOUT_DEFAULT  = 16;
  localparam logic [7:0]  TIMEOUT_ERR_DATA = 8'hFF;

endpackage

// File: rtl/bus_responder_if.sv
// bus_responder_if: CPU bus plus backing-memory port of the bus responder.
//   CPU side   : cpu_ph2, cpu_a, cpu_rw, cpu_d_in -> responder; cpu_d_out, cpu_d_oe, cpu_rdy <-
//   Memory side: mem_req, mem_we, mem_addr, mem_wdata <- responder; mem_rdata, mem_ack ->
//   Status     : bus_err (sticky timeout flag)
// Modports: slave = the responder, master = CPU/memory environment.
interface bus_responder_if;
  logic        cpu_ph2;
  logic [15:0] cpu_a;
  logic        cpu_rw;
  logic [7:0]  cpu_d_in;
  logic [7:0]  cpu_d_out;
  logic        cpu_d_oe;
  logic        cpu_rdy;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        bus_err;

  modport slave (
    input  cpu_ph2, cpu_a, cpu_rw, cpu_d_in, mem_rdata, mem_ack,
    output cpu_d_out, cpu_d_oe, cpu_rdy, mem_req, mem_we, mem_addr, mem_wdata, bus_err
  );

  modport master (
    output cpu_ph2, cpu_a, cpu_rw, cpu_d_in, mem_rdata, mem_ack,
    input  cpu_d_out, cpu_d_oe, cpu_rdy, mem_req, mem_we, mem_addr, mem_wdata, bus_err
  );
endinterface

// File: rtl/ph2_edge_detect.sv
// ph2_edge_detect: registers the CPU phase-2 level and flags its edges.
//   i_clk   - ph0 clock          i_reset - synchronous active-high reset
//   i_ph2   - cpu_ph2 level      o_rise  - ph2 low last clock, high now
//   o_fall  - ph2 high last clock, low now
module ph2_edge_detect (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_ph2,
  output logic o_rise,
  output logic o_fall
);

  logic r_ph2_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ph2_q <= 1'b0;
    end else begin
      r_ph2_q <= i_ph2;
    end
  end

  assign o_rise = i_ph2 & ~r_ph2_q;
  assign o_fall = ~i_ph2 & r_ph2_q;

endmodule

// File: rtl/bus_responder.sv
// bus_responder: memory-mapped target on the k6502 address/data bus.
// A ph2 rising edge whose address hits the window (cpu_a & ADDR_MASK) == BASE_ADDR starts one
// req/ack transaction on the memory port while the CPU is stalled via cpu_rdy. Read data is
// driven back (cpu_d_oe) for as long as ph2 stays high. All outputs are registered.
//   i_ph0   - sole clock (rising edge)     i_reset - synchronous active-high reset
//   io_bus  - bus_responder_if.slave (CPU bus, memory port, bus_err)
// Optional feature macro BUS_RESPONDER_TIMEOUT_EN: abort REQ after TIMEOUT clocks without ack,
// return TIMEOUT_ERR_DATA and set the sticky bus_err. Undefined: REQ waits forever, bus_err=0.
module bus_responder
  import bus_responder_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter logic [15:0] ADDR_MASK = 16'hF800,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEFAULT
) (
  input logic            i_ph0,
  input logic            i_reset,
  bus_responder_if.slave io_bus
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("bus_responder: TIMEOUT must be in 1..255");
  end

  state_e      r_state;
  logic [7:0]  r_cpu_d_out;
  logic        r_cpu_d_oe;
  logic        r_cpu_rdy;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [15:0] r_mem_addr;
  logic [7:0]  r_mem_wdata;

  logic        w_ph2_rise;
  logic        w_ph2_fall_unused;
  logic        w_hit;
  logic        w_done;
  logic [7:0]  w_rdata;

  ph2_edge_detect u_ph2_edge (
    .i_clk   (i_ph0),
    .i_reset (i_reset),
    .i_ph2   (io_bus.cpu_ph2),
    .o_rise  (w_ph2_rise),
    .o_fall  (w_ph2_fall_unused)
  );

  assign w_hit = (io_bus.cpu_a & ADDR_MASK) == BASE_ADDR;

`ifdef BUS_RESPONDER_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  logic [7:0] r_cnt;
  logic       r_bus_err;
  logic       w_expire;

  // Expiry fires on the TIMEOUT-th REQ clock; an ack on that same clock takes precedence.
  always_comb begin
    w_expire = ~io_bus.mem_ack && (r_cnt == TIMEOUT_LAST);
    w_done   = io_bus.mem_ack | w_expire;
    w_rdata  = io_bus.mem_ack ? io_bus.mem_rdata : TIMEOUT_ERR_DATA;
  end

  always_ff @(posedge i_ph0) begin
    if (i_reset) begin
      r_cnt     <= 8'd0;
      r_bus_err <= 1'b0;
    end else begin
      if (r_state == IDLE) begin
        r_cnt <= 8'd0;
      end else if (r_state == REQ && !w_done) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (r_state == REQ && w_expire) begin
        r_bus_err <= 1'b1;
      end
    end
  end

  assign io_bus.bus_err = r_bus_err;
`else
  always_comb begin
    w_done  = io_bus.mem_ack;
    w_rdata = io_bus.mem_rdata;
  end

  assign io_bus.bus_err = 1'b0;
`endif

  always_ff @(posedge i_ph0) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_cpu_d_out <= 8'h00;
      r_cpu_d_oe  <= 1'b0;
      r_cpu_rdy   <= 1'b1;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 16'h0000;
      r_mem_wdata <= 8'h00;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_ph2_rise && w_hit) begin
            r_mem_addr  <= io_bus.cpu_a;
            r_mem_we    <= (io_bus.cpu_rw != RW_READ);
            r_mem_wdata <= io_bus.cpu_d_in;
            r_mem_req   <= 1'b1;
            r_cpu_rdy   <= 1'b0;
            r_state     <= REQ;
          end
        end
        REQ: begin
          if (w_done) begin
            r_mem_req <= 1'b0;
            r_cpu_rdy <= 1'b1;
            if (!r_mem_we) begin
              r_cpu_d_out <= w_rdata;
              r_cpu_d_oe  <= io_bus.cpu_ph2;
            end
            // If ph2 already fell there is nothing to hold; skip straight back to IDLE.
            r_state <= io_bus.cpu_ph2 ? HOLD : IDLE;
          end
        end
        HOLD: begin
          if (!io_bus.cpu_ph2) begin
            r_cpu_d_oe <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_bus.cpu_d_out = r_cpu_d_out;
  assign io_bus.cpu_d_oe  = r_cpu_d_oe;
  assign io_bus.cpu_rdy   = r_cpu_rdy;
  assign io_bus.mem_req   = r_mem_req;
  assign io_bus.mem_we    = r_mem_we;
  assign io_bus.mem_addr  = r_mem_addr;
  assign io_bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_bus_responder.sv
// tb_bus_responder: scoreboard bench for bus_responder. Stimulus pushes the expected memory
// request and the expected completion (data, drive enable, stall length, bus_err); a monitor
// pops and compares whenever mem_req rises or cpu_rdy returns high.
module tb_bus_responder;

  typedef struct packed {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
  } req_t;

  typedef struct {
    logic [7:0] dout;
    logic       oe;
    int         stall;
    logic       err;
  } done_t;

  logic clk;
  logic rst;
  bus_responder_if bif ();

  bus_responder #(
    .BASE_ADDR (16'h0000),
    .ADDR_MASK (16'hF800),
    .TIMEOUT   (4)
  ) dut (
    .i_ph0   (clk),
    .i_reset (rst),
    .io_bus  (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_bad = 0;
  bit    mon_en = 1'b0;
  logic  exp_err = 1'b0;
  req_t  exp_req[$];
  done_t exp_done[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    logic prev_req, prev_rdy;
    int   req_len, stall_cnt;
    req_t  r;
    done_t d;
    prev_req = 1'b0;
    prev_rdy = 1'b1;
    req_len = 0;
    stall_cnt = 0;
    wait (mon_en);
    forever begin
      @(posedge clk);
      #1;
      if (bif.mem_req && !prev_req) begin
        if (exp_req.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_req: mem_req rose with addr %0h, none expected", bif.mem_addr);
        end else begin
          r = exp_req.pop_front();
          chk("req_addr", {16'h0, bif.mem_addr}, {16'h0, r.addr});
          chk("req_we", {31'h0, bif.mem_we}, {31'h0, r.we});
          chk("req_wdata", {24'h0, bif.mem_wdata}, {24'h0, r.wdata});
        end
      end
      if (bif.mem_req) req_len++;
      if (!bif.cpu_rdy) stall_cnt++;
      if (bif.cpu_rdy && !prev_rdy) begin
        if (exp_done.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: cpu_rdy rose, no completion expected");
        end else begin
          d = exp_done.pop_front();
          chk("done_dout", {24'h0, bif.cpu_d_out}, {24'h0, d.dout});
          chk("done_oe", {31'h0, bif.cpu_d_oe}, {31'h0, d.oe});
          chk("done_stall", stall_cnt, d.stall);
          chk("done_req_len", req_len, d.stall);
          chk("done_bus_err", {31'h0, bif.bus_err}, {31'h0, d.err});
        end
        stall_cnt = 0;
        req_len = 0;
      end
      prev_req = bif.mem_req;
      prev_rdy = bif.cpu_rdy;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // One hit transaction. stall = REQ clocks until ack (or timeout); ack is already high at the
  // start edge when stall==1, exercising "ack outside REQ ignored". Inputs are scrambled after
  // capture to show they are latched once.
  task automatic run_txn(input logic [15:0] a, input logic rw, input logic [7:0] din,
                         input logic [7:0] rd, input int stall, input bit early,
                         input bit no_ack, input logic [7:0] exp_dout);
    done_t d;
    @(negedge clk);
    bif.cpu_a = a;
    bif.cpu_rw = rw;
    bif.cpu_d_in = din;
    bif.mem_rdata = rd;
    bif.cpu_ph2 = 1'b1;
    bif.mem_ack = (stall == 1) && !no_ack;
    exp_req.push_back('{addr: a, we: ~rw, wdata: din});
    d.dout = exp_dout;
    d.oe = rw && !early;
    d.stall = stall;
    d.err = exp_err;
    exp_done.push_back(d);
    for (int i = 1; i <= stall; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bif.cpu_a = ~a;
        bif.cpu_d_in = ~din;
        bif.cpu_rw = ~rw;
        if (early) bif.cpu_ph2 = 1'b0;
      end
      if (i == stall && !no_ack) bif.mem_ack = 1'b1;
    end
    @(negedge clk);
    bif.mem_ack = 1'b0;
    chk("captured_addr", {16'h0, bif.mem_addr}, {16'h0, a});
    chk("captured_wdata", {24'h0, bif.mem_wdata}, {24'h0, din});
    chk("captured_we", {31'h0, bif.mem_we}, {31'h0, ~rw});
    if (!early) begin
      @(negedge clk);
      chk("hold_oe", {31'h0, bif.cpu_d_oe}, {31'h0, rw});
      bif.cpu_ph2 = 1'b0;
    end
    @(negedge clk);
    chk("after_oe", {31'h0, bif.cpu_d_oe}, 32'h0);
    chk("after_dout", {24'h0, bif.cpu_d_out}, {24'h0, exp_dout});
    chk("after_rdy", {31'h0, bif.cpu_rdy}, 32'h1);
    bif.cpu_a = 16'h0000;
    bif.cpu_rw = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    bif.cpu_ph2 = 1'b0;
    bif.cpu_a = 16'h0000;
    bif.cpu_rw = 1'b1;
    bif.cpu_d_in = 8'h00;
    bif.mem_rdata = 8'h00;
    bif.mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_dout", {24'h0, bif.cpu_d_out}, 32'h0);
    chk("rst_oe", {31'h0, bif.cpu_d_oe}, 32'h0);
    chk("rst_rdy", {31'h0, bif.cpu_rdy}, 32'h1);
    chk("rst_req", {31'h0, bif.mem_req}, 32'h0);
    chk("rst_we", {31'h0, bif.mem_we}, 32'h0);
    chk("rst_addr", {16'h0, bif.mem_addr}, 32'h0);
    chk("rst_wdata", {24'h0, bif.mem_wdata}, 32'h0);
    chk("rst_bus_err", {31'h0, bif.bus_err}, 32'h0);
    mon_en = 1'b1;
    @(negedge clk);

    // Read hit, zero wait.
    run_txn(16'h0123, 1'b1, 8'h00, 8'hA5, 1, 1'b0, 1'b0, 8'hA5);
    // Write hit at the top of the window, 3-clock stall; cpu_d_out keeps the last read value.
    run_txn(16'h07FF, 1'b0, 8'h3C, 8'h99, 3, 1'b0, 1'b0, 8'hA5);

    // Miss just above the window, even with ack high.
    @(negedge clk);
    bif.cpu_a = 16'h0800;
    bif.cpu_rw = 1'b1;
    bif.cpu_ph2 = 1'b1;
    bif.mem_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("miss_req", {31'h0, bif.mem_req}, 32'h0);
      chk("miss_rdy", {31'h0, bif.cpu_rdy}, 32'h1);
      chk("miss_oe", {31'h0, bif.cpu_d_oe}, 32'h0);
    end
    bif.cpu_ph2 = 1'b0;
    bif.mem_ack = 1'b0;
    @(negedge clk);

    // Reset two clocks after mem_req rises; a late ack must be ignored.
    @(negedge clk);
    bif.cpu_a = 16'h0042;
    bif.cpu_rw = 1'b1;
    bif.cpu_d_in = 8'h00;
    bif.mem_rdata = 8'h77;
    bif.cpu_ph2 = 1'b1;
    exp_req.push_back('{addr: 16'h0042, we: 1'b0, wdata: 8'h00});
    exp_done.push_back('{dout: 8'h00, oe: 1'b0, stall: 2, err: 1'b0});
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bif.cpu_ph2 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_req", {31'h0, bif.mem_req}, 32'h0);
    chk("rstmid_rdy", {31'h0, bif.cpu_rdy}, 32'h1);
    chk("rstmid_addr", {16'h0, bif.mem_addr}, 32'h0);
    chk("rstmid_dout", {24'h0, bif.cpu_d_out}, 32'h0);
    bif.mem_ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rstmid_late_ack_oe", {31'h0, bif.cpu_d_oe}, 32'h0);
      chk("rstmid_late_ack_rdy", {31'h0, bif.cpu_rdy}, 32'h1);
    end
    bif.mem_ack = 1'b0;
    @(negedge clk);

    // Early ph2 fall: data latched, no drive, back to IDLE; next read serviced normally.
    run_txn(16'h0100, 1'b1, 8'h00, 8'h5A, 3, 1'b1, 1'b0, 8'h5A);
    run_txn(16'h0200, 1'b1, 8'h00, 8'hC3, 2, 1'b0, 1'b0, 8'hC3);

`ifdef BUS_RESPONDER_TIMEOUT_EN
    // Timeout after 4 REQ clocks without ack, then bus_err stays set over a normal read.
    exp_err = 1'b1;
    run_txn(16'h0300, 1'b1, 8'h00, 8'h12, 4, 1'b0, 1'b1, 8'hFF);
    run_txn(16'h0301, 1'b1, 8'h00, 8'h11, 1, 1'b0, 1'b0, 8'h11);
    chk("bus_err_sticky", {31'h0, bif.bus_err}, 32'h1);
`else
    chk("bus_err_tied", {31'h0, bif.bus_err}, 32'h0);
`endif

    repeat (3) @(negedge clk);
    chk("req_queue_empty", exp_req.size(), 0);
    chk("done_queue_empty", exp_done.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
